// File: rtl/alu_mdu_ctrl.sv
// ALU control decode plus an iterative RV32M multiply/divide unit.
// The MDU stalls the pipeline with busy_o and signals completion with a one-cycle done_o pulse.
`timescale 1ns/1ps
module alu_mdu_ctrl #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic              flush_i,
   input  logic [1:0]        ALUOp_i,
   input  logic              opb5_i,
   input  logic [2:0]        funct3_i,
   input  logic              funct7b5_i,
   input  logic              funct7b0_i,
   input  logic [XLEN-1:0]   srca_i,
   input  logic [XLEN-1:0]   srcb_i,
   output logic [CTRL_W-1:0] ALUControl_o,
   output logic              mdu_sel_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [XLEN-1:0]   result_o
);
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  acc_hi;
   logic [XLEN-1:0]  acc_lo;
   logic [XLEN-1:0]  opb_mag;
   logic [2:0]       op;
   logic             neg_res;
   logic             done_q;
   logic [XLEN-1:0]  result_q;

   logic             mul_req;
   logic [3:0]       alu_code;

   logic             is_div, a_signed, b_signed, a_neg, b_neg;
   logic             div_zero, div_ovf;
   logic [XLEN-1:0]  a_mag, b_mag, fast_result;

   logic [XLEN:0]    add_sum, trial;
   logic [XLEN-1:0]  trial_diff, hi_nx, lo_nx, quo, remv, calc_result;
   logic [2*XLEN-1:0] prod, prod_signed;

   assign mul_req   = valid_i & (ALUOp_i == 2'b10) & opb5_i & funct7b0_i;
   assign mdu_sel_o = mul_req;
   assign busy_o    = ((state == IDLE) & mul_req) | (state == CALC);
   assign done_o    = done_q;
   assign result_o  = result_q;

   always_comb begin
      alu_code = 4'b0000;
      if (ALUOp_i == 2'b00) begin
         alu_code = 4'b0000;
      end else if (ALUOp_i == 2'b01) begin
         alu_code = 4'b0001;
      end else begin
         case (funct3_i)
            3'b000:  alu_code = (funct7b5_i & opb5_i) ? 4'b0001 : 4'b0000;
            3'b001:  alu_code = 4'b0110;
            3'b010:  alu_code = 4'b0101;
            3'b011:  alu_code = 4'b1001;
            3'b100:  alu_code = 4'b0100;
            3'b101:  alu_code = funct7b5_i ? 4'b1000 : 4'b0111;
            3'b110:  alu_code = 4'b0011;
            default: alu_code = 4'b0010;
         endcase
      end
      ALUControl_o      = '0;
      ALUControl_o[3:0] = alu_code;
   end

   // Operand signedness: mul/mulh fully signed, mulhsu signed rs1 only, odd divide ops unsigned.
   always_comb begin
      is_div      = funct3_i[2];
      a_signed    = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
      b_signed    = is_div ? ~funct3_i[0] : ~funct3_i[1];
      a_neg       = a_signed & srca_i[XLEN-1];
      b_neg       = b_signed & srcb_i[XLEN-1];
      a_mag       = a_neg ? -srca_i : srca_i;
      b_mag       = b_neg ? -srcb_i : srcb_i;
      div_zero    = is_div & (srcb_i == '0);
      div_ovf     = is_div & ~funct3_i[0] & (srca_i == {1'b1, {(XLEN-1){1'b0}}}) & (&srcb_i);
      fast_result = div_zero ? (funct3_i[1] ? srca_i : '1) : (funct3_i[1] ? '0 : srca_i);
   end

   // acc_hi holds the partial product high half or the partial remainder; acc_lo the multiplier or quotient.
   always_comb begin
      add_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_mag} : '0);
      trial      = {acc_hi, acc_lo[XLEN-1]};
      trial_diff = trial[XLEN-1:0] - opb_mag;
      hi_nx      = add_sum[XLEN:1];
      lo_nx      = {add_sum[0], acc_lo[XLEN-1:1]};
      if (op[2]) begin
         if (trial >= {1'b0, opb_mag}) begin
            hi_nx = trial_diff;
            lo_nx = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            hi_nx = trial[XLEN-1:0];
            lo_nx = {acc_lo[XLEN-2:0], 1'b0};
         end
      end
      prod        = {hi_nx, lo_nx};
      prod_signed = neg_res ? -prod : prod;
      quo         = neg_res ? -lo_nx : lo_nx;
      remv        = neg_res ? -hi_nx : hi_nx;
      if (op[2])
         calc_result = op[1] ? remv : quo;
      else if (op[1:0] == 2'b00)
         calc_result = prod_signed[XLEN-1:0];
      else
         calc_result = prod_signed[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opb_mag  <= '0;
         op       <= '0;
         neg_res  <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (flush_i) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (mul_req) begin
                     op      <= funct3_i;
                     neg_res <= (is_div & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
                     acc_hi  <= '0;
                     acc_lo  <= a_mag;
                     opb_mag <= b_mag;
                     if (div_zero | div_ovf) begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        result_q <= fast_result;
                     end else begin
                        state <= CALC;
                        cnt   <= CNT_W'(XLEN - 1);
                     end
                  end
               end
               CALC: begin
                  acc_hi <= hi_nx;
                  acc_lo <= lo_nx;
                  if (cnt == '0) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     result_q <= calc_result;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench for alu_mdu_ctrl: an arithmetic reference model plus a latency
// countdown predicts every output on every cycle, with literal expectations pinning the model.
`timescale 1ns/1ps
module tb_alu_mdu_ctrl;
   localparam int XLEN   = 32;
   localparam int CTRL_W = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              valid_i;
   logic              flush_i;
   logic [1:0]        ALUOp_i;
   logic              opb5_i;
   logic [2:0]        funct3_i;
   logic              funct7b5_i;
   logic              funct7b0_i;
   logic [XLEN-1:0]   srca_i;
   logic [XLEN-1:0]   srcb_i;
   logic [CTRL_W-1:0] ALUControl_o;
   logic              mdu_sel_o;
   logic              busy_o;
   logic              done_o;
   logic [XLEN-1:0]   result_o;

   int n_checks = 0;
   int n_pass   = 0;
   int done_seen = 0;

   int          m_left   = 0;
   logic        m_done   = 1'b0;
   logic [31:0] m_result = '0;
   logic [31:0] m_pend   = '0;

   alu_mdu_ctrl #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
      .ALUOp_i(ALUOp_i), .opb5_i(opb5_i), .funct3_i(funct3_i),
      .funct7b5_i(funct7b5_i), .funct7b0_i(funct7b0_i),
      .srca_i(srca_i), .srcb_i(srcb_i), .ALUControl_o(ALUControl_o),
      .mdu_sel_o(mdu_sel_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [3:0] expCtrl(input logic [1:0] aop, input logic ob5,
                                          input logic [2:0] f3, input logic f7b5);
      if (aop == 2'b00) return 4'd0;
      if (aop == 2'b01) return 4'd1;
      case (f3)
         3'd0: return (f7b5 && ob5) ? 4'd1 : 4'd0;
         3'd1: return 4'd6;
         3'd2: return 4'd5;
         3'd3: return 4'd9;
         3'd4: return 4'd4;
         3'd5: return f7b5 ? 4'd8 : 4'd7;
         3'd6: return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q;
      logic [63:0] ua, ub, p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            q = sa / sb; return q[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            q = sa % sb; return q[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic isFast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Reference timeline: a started op finishes XLEN+1 cycles later (1 on the fast path).
   always @(posedge clk_i or posedge rst_i) begin
      logic was_done;
      if (rst_i) begin
         m_left = 0; m_done = 1'b0; m_result = '0; m_pend = '0;
      end else begin
         was_done = m_done;
         m_done   = 1'b0;
         if (flush_i) begin
            m_left = 0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_done = 1'b1; m_result = m_pend; end
         end else if (!was_done && valid_i && ALUOp_i == 2'b10 && opb5_i && funct7b0_i) begin
            m_pend = refResult(funct3_i, srca_i, srcb_i);
            if (isFast(funct3_i, srca_i, srcb_i)) begin m_done = 1'b1; m_result = m_pend; end
            else m_left = XLEN;
         end
      end
   end

   always @(negedge clk_i) begin
      logic mreq;
      mreq = valid_i && ALUOp_i == 2'b10 && opb5_i && funct7b0_i;
      if (done_o === 1'b1) done_seen++;
      checkOutput("ctrl", ALUControl_o, expCtrl(ALUOp_i, opb5_i, funct3_i, funct7b5_i));
      checkOutput("mdu_sel", mdu_sel_o, mreq);
      checkOutput("busy", busy_o, (m_left > 0) || (!m_done && mreq));
      checkOutput("done", done_o, m_done);
      checkOutput("result", result_o, m_result);
   end

   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input int flush_at, output int lat, output int busy_cnt);
      valid_i = 1'b1; ALUOp_i = 2'b10; opb5_i = 1'b1; funct7b0_i = 1'b1;
      funct7b5_i = 1'($urandom_range(0, 1)); funct3_i = f3; srca_i = a; srcb_i = b;
      lat = -1;
      busy_cnt = 0;
      for (int cyc = 0; cyc < 64; cyc++) begin
         flush_i = (cyc == flush_at);
         #3;
         if (busy_o === 1'b1) busy_cnt++;
         @(posedge clk_i); #1;
         flush_i = 1'b0;
         if (cyc == flush_at) break;
         if (done_o === 1'b1) begin lat = cyc + 1; break; end
      end
      valid_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   logic [2:0]  d_f3  [11] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
   logic [31:0] d_a   [11] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] d_b   [11] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] d_r   [11] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
   int          d_lat [11] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

   initial begin
      int lat, bc, fl, seen_before;
      logic [2:0] f3;
      logic [31:0] a, b;
      rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ALUOp_i = 2'b00; opb5_i = 1'b0;
      funct3_i = 3'd0; funct7b5_i = 1'b0; funct7b0_i = 1'b0; srca_i = '0; srcb_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("reset_busy", busy_o, 1'b0);
      checkOutput("reset_done", done_o, 1'b0);
      checkOutput("reset_result", result_o, 32'h0);
      rst_i = 1'b0;

      ALUOp_i = 2'b10; opb5_i = 1'b1; funct7b5_i = 1'b1; funct3_i = 3'b101; #1;
      checkOutput("dec_sra", ALUControl_o, 4'b1000);
      funct3_i = 3'b011; #1;
      checkOutput("dec_sltu", ALUControl_o, 4'b1001);
      funct3_i = 3'b000; #1;
      checkOutput("dec_sub", ALUControl_o, 4'b0001);
      ALUOp_i = 2'b00; #1;
      checkOutput("dec_add", ALUControl_o, 4'b0000);
      @(posedge clk_i); #1;

      for (int i = 0; i < 11; i++) begin
         checkOutput("model_pin", refResult(d_f3[i], d_a[i], d_b[i]), d_r[i]);
         applyStimulus(d_f3[i], d_a[i], d_b[i], -1, lat, bc);
         checkOutput("dir_latency", lat, d_lat[i]);
         checkOutput("dir_busy_cycles", bc, d_lat[i]);
         checkOutput("dir_result", result_o, d_r[i]);
      end

      seen_before = done_seen;
      applyStimulus(3'd0, 32'h1234, 32'h5678, 10, lat, bc);
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("flush_no_done", done_seen - seen_before, 0);
      checkOutput("flush_idle_busy", busy_o, 1'b0);

      valid_i = 1'b1; ALUOp_i = 2'b10; opb5_i = 1'b1; funct7b0_i = 1'b1;
      funct3_i = 3'd1; srca_i = 32'h1357_9BDF; srcb_i = 32'h2468_ACE0;
      repeat (6) @(posedge clk_i);
      #2;
      rst_i = 1'b1; valid_i = 1'b0;
      #1;
      checkOutput("rst_mid_busy", busy_o, 1'b0);
      checkOutput("rst_mid_done", done_o, 1'b0);
      checkOutput("rst_mid_result", result_o, 32'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, -1, lat, bc);
      checkOutput("post_rst_latency", lat, 33);
      checkOutput("post_rst_result", result_o, 32'hFFFF_FFEB);

      for (int n = 0; n < 150; n++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = pickOperand();
         b  = pickOperand();
         fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 34)) : -1;
         applyStimulus(f3, a, b, fl, lat, bc);
         if (fl < 0) checkOutput("rand_completes", lat > 0, 1'b1);
         repeat ($urandom_range(0, 2)) begin
            ALUOp_i = 2'($urandom_range(0, 3)); opb5_i = 1'($urandom_range(0, 1));
            funct3_i = 3'($urandom_range(0, 7)); funct7b5_i = 1'($urandom_range(0, 1));
            funct7b0_i = 1'($urandom_range(0, 1)); valid_i = 1'($urandom_range(0, 1));
            if (ALUOp_i == 2'b10 && opb5_i && funct7b0_i) valid_i = 1'b0;
            @(posedge clk_i); #1;
         end
         valid_i = 1'b0;
      end

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/alu_mdu_ctrl.md
Name: alu_mdu_ctrl

Overview:
Second-generation ALU control block for the RV32 pipeline. It has two parts:
- Combinational decode of ALUOp/funct3/funct7 into a widened ALU control code, now including sra and sltu.
- A sequential multiply/divide unit (RV32M) that runs iteratively and stalls the pipeline through a busy/done handshake.

It sits in the execute stage beside the ALU. The hazard unit consumes busy_o.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- CTRL_W, 4, ALUControl_o width; must be >= 4, upper bits zero-filled.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  execute-stage instruction valid.
- flush_i  in  1  abort any MDU operation.
- ALUOp_i  in  2  main-decoder ALU op class.
- opb5_i  in  1  opcode bit 5 (1 = R-type).
- funct3_i  in  3  instruction funct3.
- funct7b5_i  in  1  funct7 bit 5.
- funct7b0_i  in  1  funct7 bit 0 (1 = M-extension).
- srca_i  in  XLEN  rs1 operand.
- srcb_i  in  XLEN  rs2 operand.
- ALUControl_o  out  CTRL_W  ALU operation code.
- mdu_sel_o  out  1  1 = writeback takes result_o instead of the ALU.
- busy_o  out  1  stall request to the hazard unit.
- done_o  out  1  one-cycle pulse, result_o valid.
- result_o  out  XLEN  MDU result.

Behaviour:
- ALU decode (combinational, all codes zero-extended to CTRL_W):
  - ALUOp 00 -> 0000 (add); ALUOp 01 -> 0001 (sub).
  - Otherwise by funct3:
    - 000: 0001 if funct7b5&opb5, else 0000.
    - 001: 0110 (sll).
    - 010: 0101 (slt).
    - 011: 1001 (sltu).
    - 100: 0100 (xor).
    - 101: 1000 (sra) if funct7b5, else 0111 (srl).
    - 110: 0011 (or).
    - 111: 0010 (and).
  - No x outputs.
- mul_req = valid_i & ALUOp==10 & opb5 & funct7b0. mdu_sel_o = mul_req (combinational).
- funct3 selects the M op:
  - 000 mul, 001 mulh, 010 mulhsu, 011 mulhu.
  - 100 div, 101 divu, 110 rem, 111 remu.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - mul_req=1 -> latch operands, op and the magnitude/sign info.
  - Divisor 0, or signed overflow (div/rem, srca=100..0, srcb=all ones) -> DONE directly.
  - Otherwise -> CALC with counter = XLEN-1.
- CALC:
  - One iteration per cycle: shift-add multiply on magnitudes over 2*XLEN bits, restoring division on magnitudes.
  - Counter decrements; at 0 -> DONE. CALC lasts exactly XLEN cycles.
- DONE:
  - done_o=1 and result_o registered; next state IDLE.
  - Starts are evaluated only in IDLE, so an instruction waiting in DONE is not restarted.
- busy_o = (IDLE & mul_req) | CALC. It is 0 in DONE, so the stalled instruction advances that cycle.
- Normal latency: request at cycle 0, done_o at cycle XLEN+1, busy_o high for cycles 0..XLEN.
- Fast-path latency: done_o at cycle 1.
- Sign handling:
  - Operand magnitudes are taken per op signedness (mulhsu: srca signed, srcb unsigned).
  - The result is negated when signs differ (quotient/product); a remainder takes the dividend's sign.
- Result selection:
  - mul: low XLEN bits of the product.
  - mulh/mulhsu/mulhu: high XLEN bits.
- Divide by zero: quotient = all ones (div and divu); remainder = dividend.
- Signed overflow: quotient = dividend (100..0); remainder = 0.
- flush_i (sampled on any edge, highest priority after reset):
  - Next state IDLE; done_o stays 0; result_o holds its old value.
  - A flush in IDLE blocks a start in that cycle.
- Reset (asynchronous, including mid-operation):
  - State IDLE; counter 0.
  - done_o=0, result_o=0, busy_o=0 once mul_req is low.
  - Internal accumulators are cleared.
- result_o holds its value until the next DONE.

Test Plan:
- Decode sweep: ALUOp=10, opb5=1, funct7b5=1, funct3=101 -> ALUControl_o=1000; funct3=011 -> 1001; funct3=000 -> 0001; ALUOp=00 -> 0000; no x outputs on any input.
- mul: srca=7, srcb=-3 (0xFFFFFFFD), funct3=000 -> busy_o high 33 cycles, done_o at cycle 33, result_o=0xFFFFFFEB.
- mulhu: 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. mulh: 0x80000000 × 0x80000000 -> 0x40000000.
- div: -7/2 -> 0xFFFFFFFD; rem: -7 rem 2 -> 0xFFFFFFFF; divu: 100/7 -> 14; remu: 100 rem 7 -> 2.
- Fast path: div 5/0 -> 0xFFFFFFFF with done_o at cycle 1; rem 5 rem 0 -> 5; div 0x80000000/-1 -> 0x80000000; rem of the same operands -> 0.
- Abort: flush_i at CALC cycle 10 -> IDLE, no done_o pulse. rst_i asserted mid-CALC -> all outputs 0 immediately. A new mul afterwards completes with correct latency.
